// File: rtl/fetch_halt_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: PC width, special
// instruction words and the two-state fetch FSM encoding.
package fetch_halt_unit_pkg;

    localparam int PC_W = 8;

    localparam logic [15:0] HALT_WORD_DEF = 16'h0001;
    localparam logic [15:0] NOP_WORD      = 16'h0000;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/fetch_halt_unit_edge_detect_rise.sv
// Rising-edge detector for a debounced front-panel button level.
// The output pulses for the single cycle in which the level goes 0 -> 1.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_d;
    logic din_q;

    always_comb begin
        din_d = din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/fetch_halt_unit.sv
// Instruction fetch: owns the PC, forwards RAM words to the decoder, stops on
// the HALT word and waits for a RESUME button edge to continue.
module fetch_halt_unit
    import fetch_halt_unit_pkg::*;
#(
    parameter logic [15:0]     HALT_WORD = HALT_WORD_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = 8'h00,
    parameter int              PC_STEP   = 2,
    parameter int              CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [15:0]      INSTR,
    input  logic             BRANCH_TAKEN,
    input  logic [PC_W-1:0]  BRANCH_TARGET,
    input  logic             RESUME,
    output logic [PC_W-1:0]  ADDR,
    output logic [15:0]      INSTR_OUT,
    output logic             INSTR_VALID,
    output logic             HALTED,
    output logic [CNT_W-1:0] HALT_COUNT
);

    logic [PC_W-1:0]  pc_d,         pc_q;
    logic [0:0]       state_d,      state_q;
    logic [CNT_W-1:0] halt_count_d, halt_count_q;
    logic             resume_rise;
    logic             is_halt;
    logic [PC_W-1:0]  pc_next_seq;
    logic [PC_W-1:0]  branch_pc;

    edge_detect_rise u_resume_edge (
        .clk  (CLK),
        .rst  (RESET),
        .din  (RESUME),
        .rise (resume_rise)
    );

    always_comb begin
        is_halt     = (INSTR == HALT_WORD);
        pc_next_seq = pc_q + PC_W'(PC_STEP);
        // Instructions are word aligned, so bit 0 of a redirect is dropped.
        branch_pc   = BRANCH_TARGET & ~PC_W'(1);
    end

    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        halt_count_d = halt_count_q;
        INSTR_VALID  = 1'b0;
        INSTR_OUT    = NOP_WORD;

        if (state_q == ST_RUN) begin
            if (is_halt) begin
                state_d = ST_HALTED;
                if (halt_count_q != {CNT_W{1'b1}}) begin
                    halt_count_d = halt_count_q + CNT_W'(1);
                end
            end else begin
                INSTR_VALID = ~RESET;
                INSTR_OUT   = RESET ? NOP_WORD : INSTR;
                pc_d        = BRANCH_TAKEN ? branch_pc : pc_next_seq;
            end
        end else if (resume_rise) begin
            // PC still points at the HALT word; step past it.
            pc_d    = pc_next_seq;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q         <= RESET_PC;
            state_q      <= ST_RUN;
            halt_count_q <= '0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            halt_count_q <= halt_count_d;
        end
    end

    assign ADDR       = pc_q;
    assign HALTED     = (state_q == ST_HALTED);
    assign HALT_COUNT = halt_count_q;

endmodule

// File: tb/tb_fetch_halt_unit.sv
// Directed bench for fetch_halt_unit with a behavioural instruction RAM.
module tb_fetch_halt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        resume;
    logic [7:0]  addr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic [7:0]  halt_count;

    logic [15:0] mem [0:127];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] HALT = 16'h0001;

    always #5 clk = ~clk;

    assign instr = mem[addr[7:1]];

    fetch_halt_unit dut (
        .CLK           (clk),
        .RESET         (rst),
        .INSTR         (instr),
        .BRANCH_TAKEN  (br_taken),
        .BRANCH_TARGET (br_target),
        .RESUME        (resume),
        .ADDR          (addr),
        .INSTR_OUT     (instr_out),
        .INSTR_VALID   (instr_valid),
        .HALTED        (halted),
        .HALT_COUNT    (halt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
    endtask

    task automatic reset_dut();
        rst = 1'b1; br_taken = 1'b0; br_target = 8'h00; resume = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Step until HALTED rises, bounded; checks the halt address and count.
    task automatic run_to_halt(input logic [7:0] exp_addr, input logic [7:0] exp_cnt);
        int n = 0;
        while (!halted && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (!halted) begin
            n_fail++;
            $display("FAIL run_to_halt: HALTED never rose, addr=%h required halt at %h", addr, exp_addr);
        end
        n_checks++;
        if (addr !== exp_addr) begin
            n_fail++;
            $display("FAIL halt_addr: got %h required %h", addr, exp_addr);
        end
        n_checks++;
        if (halt_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL halt_count: got %0d required %0d", halt_count, exp_cnt);
        end
    endtask

    // Single RESUME press; the next instruction must be valid at exp_addr.
    task automatic pulse_resume(input logic [7:0] exp_addr);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        n_checks++;
        if (addr !== exp_addr || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL resume: addr=%h halted=%b required addr=%h halted=0", addr, halted, exp_addr);
        end
    endtask

    task automatic test_reset();
        fill_mem();
        rst = 1'b1; br_taken = 1'b1; br_target = 8'h40; resume = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({addr, halted, halt_count} !== {8'h00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: addr=%h halted=%b cnt=%0d required 00/0/0", addr, halted, halt_count);
        end
        n_checks++;
        if (instr_valid !== 1'b0 || instr_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b out=%h required 0/0000", instr_valid, instr_out);
        end
        br_taken = 1'b0;
    endtask

    task automatic test_program();
        logic [15:0] prog [0:3];
        prog[0] = 16'h2210; prog[1] = 16'h2320; prog[2] = 16'h4105; prog[3] = 16'h6302;
        fill_mem();
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        mem[4] = HALT;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (addr !== 8'(2 * i) || instr_valid !== 1'b1 || instr_out !== prog[i]) begin
                n_fail++;
                $display("FAIL prog_step%0d: addr=%h valid=%b out=%h required addr=%h valid=1 out=%h",
                         i, addr, instr_valid, instr_out, 8'(2 * i), prog[i]);
            end
            tick();
        end
        n_checks++;
        if (addr !== 8'h08 || instr_valid !== 1'b0 || instr_out !== 16'h0000 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_present: addr=%h valid=%b out=%h halted=%b required 08/0/0000/0",
                     addr, instr_valid, instr_out, halted);
        end
        tick();
        tick();
        n_checks++;
        if ({addr, halted, instr_valid, halt_count} !== {8'h08, 1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL halted_state: addr=%h halted=%b valid=%b cnt=%0d required 08/1/0/1",
                     addr, halted, instr_valid, halt_count);
        end
    endtask

    task automatic test_resume_held();
        fill_mem();
        mem[4] = HALT;
        reset_dut();
        resume = 1'b1;
        run_to_halt(8'h08, 8'd1);
        tick();
        tick();
        n_checks++;
        if (halted !== 1'b1 || addr !== 8'h08) begin
            n_fail++;
            $display("FAIL held_resume: halted=%b addr=%h required 1/08", halted, addr);
        end
        resume = 1'b0;
        tick();
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL release_resume: halted=%b required 1", halted);
        end
        pulse_resume(8'h0A);
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== mem[5]) begin
            n_fail++;
            $display("FAIL after_resume: valid=%b out=%h required 1/%h", instr_valid, instr_out, mem[5]);
        end
    endtask

    task automatic test_multi_halt();
        fill_mem();
        mem[4] = HALT; mem[12] = HALT; mem[16] = HALT;
        reset_dut();
        run_to_halt(8'h08, 8'd1);
        pulse_resume(8'h0A);
        run_to_halt(8'h18, 8'd2);
        pulse_resume(8'h1A);
        run_to_halt(8'h20, 8'd3);
        pulse_resume(8'h22);
        n_checks++;
        if (halt_count !== 8'd3 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_count: cnt=%0d valid=%b required 3/1", halt_count, instr_valid);
        end
    endtask

    task automatic test_branch();
        fill_mem();
        mem[9] = HALT;
        reset_dut();
        tick();
        tick();
        br_taken = 1'b1; br_target = 8'h13;
        #1;
        n_checks++;
        if (addr !== 8'h04 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_src: addr=%h valid=%b required 04/1", addr, instr_valid);
        end
        tick();
        br_target = 8'h40;
        #1;
        n_checks++;
        if (addr !== 8'h12) begin
            n_fail++;
            $display("FAIL branch_target: addr=%h required 12", addr);
        end
        tick();
        br_taken = 1'b0;
        n_checks++;
        if (addr !== 8'h12 || halted !== 1'b1 || halt_count !== 8'd1) begin
            n_fail++;
            $display("FAIL branch_on_halt: addr=%h halted=%b cnt=%0d required 12/1/1", addr, halted, halt_count);
        end
    endtask

    task automatic test_wrap();
        fill_mem();
        reset_dut();
        br_taken = 1'b1; br_target = 8'hFE;
        tick();
        br_taken = 1'b0;
        #1;
        n_checks++;
        if (addr !== 8'hFE || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_reach: addr=%h valid=%b required FE/1", addr, instr_valid);
        end
        tick();
        n_checks++;
        if (addr !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_step: addr=%h required 00", addr);
        end
        mem[127] = HALT;
        br_taken = 1'b1; br_target = 8'hFF;
        tick();
        br_taken = 1'b0;
        #1;
        n_checks++;
        if (addr !== 8'hFE || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_halt_present: addr=%h valid=%b required FE/0", addr, instr_valid);
        end
        run_to_halt(8'hFE, 8'd1);
        pulse_resume(8'h00);
    endtask

    task automatic test_reset_mid_halt();
        fill_mem();
        mem[1] = HALT; mem[2] = HALT;
        reset_dut();
        run_to_halt(8'h02, 8'd1);
        pulse_resume(8'h04);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_after_resume: valid=%b required 0", instr_valid);
        end
        run_to_halt(8'h04, 8'd2);
        rst = 1'b1; resume = 1'b1; br_taken = 1'b1; br_target = 8'h30;
        tick();
        n_checks++;
        if ({addr, halted, halt_count, instr_valid} !== {8'h00, 1'b0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_halt: addr=%h halted=%b cnt=%0d valid=%b required 00/0/0/0",
                     addr, halted, halt_count, instr_valid);
        end
        n_checks++;
        if (instr_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_run_out: out=%h required 0000", instr_out);
        end
        rst = 1'b0; resume = 1'b0; br_taken = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== mem[0] || addr !== 8'h00) begin
            n_fail++;
            $display("FAIL first_fetch: valid=%b out=%h addr=%h required 1/%h/00",
                     instr_valid, instr_out, addr, mem[0]);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_resume_held();
        test_multi_halt();
        test_branch();
        test_wrap();
        test_reset_mid_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
